// File: rtl/hs_skid_pipe.sv
// hs_skid_pipe: STAGES cascaded full skid-buffer stages on a valid/ready channel.
// Define HS_PIPE_CNT_EN to add the in_cnt/out_cnt transfer counters and the occ occupancy port.
module hs_skid_pipe #(
    parameter int DATA_W = 3,
    parameter int STAGES = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_down,
    output logic [DATA_W-1:0] data_down,
    input  logic              ready_down
`ifdef HS_PIPE_CNT_EN
    ,
    output logic [15:0]                    in_cnt,
    output logic [15:0]                    out_cnt,
    output logic [$clog2(2*STAGES+1)-1:0]  occ
`endif
);

    // bit 0 mirrors the main-register valid, bit 1 the skid-register valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b11
    } stage_st_e;

    stage_st_e         r_state     [STAGES];
    logic [DATA_W-1:0] r_m_dat     [STAGES];
    logic [DATA_W-1:0] r_s_dat     [STAGES];
    stage_st_e         w_state_nxt [STAGES];
    logic [DATA_W-1:0] w_in_dat    [STAGES];

    logic [STAGES-1:0] w_m_vld;
    logic [STAGES-1:0] w_s_vld;
    logic [STAGES-1:0] w_in_vld;
    logic [STAGES-1:0] w_out_rdy;
    logic [STAGES-1:0] w_in_fire;
    logic [STAGES-1:0] w_out_fire;
    logic [STAGES-1:0] w_ld_main;
    logic [STAGES-1:0] w_ld_skid;
    logic [STAGES-1:0] w_main_from_skid;

    for (genvar gk = 0; gk < STAGES; gk++) begin : g_link
        assign w_m_vld[gk]    = (r_state[gk] != ST_EMPTY);
        assign w_s_vld[gk]    = (r_state[gk] == ST_FULL);
        // a stage takes a beat only while its skid is free
        assign w_in_fire[gk]  = w_in_vld[gk] & ~w_s_vld[gk];
        assign w_out_fire[gk] = w_m_vld[gk] & w_out_rdy[gk];

        if (gk == 0) begin : g_head
            assign w_in_vld[gk] = valid_up;
            assign w_in_dat[gk] = data_up;
        end else begin : g_mid
            assign w_in_vld[gk] = w_m_vld[gk-1];
            assign w_in_dat[gk] = r_m_dat[gk-1];
        end

        if (gk == STAGES-1) begin : g_tail
            assign w_out_rdy[gk] = ready_down;
        end else begin : g_next
            assign w_out_rdy[gk] = ~w_s_vld[gk+1];
        end
    end

    // Per-stage next state and register load enables.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_state_nxt[k]      = r_state[k];
            w_ld_main[k]        = 1'b0;
            w_ld_skid[k]        = 1'b0;
            w_main_from_skid[k] = 1'b0;
            case (r_state[k])
                ST_EMPTY: begin
                    if (w_in_fire[k]) begin
                        w_state_nxt[k] = ST_BUSY;
                        w_ld_main[k]   = 1'b1;
                    end else begin
                        w_state_nxt[k] = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    case ({w_in_fire[k], w_out_fire[k]})
                        2'b01: w_state_nxt[k] = ST_EMPTY;
                        2'b10: begin
                            w_state_nxt[k] = ST_FULL;
                            w_ld_skid[k]   = 1'b1;
                        end
                        2'b11: begin
                            w_state_nxt[k] = ST_BUSY;
                            w_ld_main[k]   = 1'b1;
                        end
                        default: w_state_nxt[k] = ST_BUSY;
                    endcase
                end
                ST_FULL: begin
                    if (w_out_fire[k]) begin
                        w_state_nxt[k]      = ST_BUSY;
                        w_ld_main[k]        = 1'b1;
                        w_main_from_skid[k] = 1'b1;
                    end else begin
                        w_state_nxt[k] = ST_FULL;
                    end
                end
                default: w_state_nxt[k] = ST_EMPTY;
            endcase
        end
    end

    // Stage state and payload registers; payload clears on reset for X-free output.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_state[k] <= ST_EMPTY;
                r_m_dat[k] <= {DATA_W{1'b0}};
                r_s_dat[k] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                r_state[k] <= w_state_nxt[k];
                if (w_ld_main[k]) begin
                    r_m_dat[k] <= w_main_from_skid[k] ? r_s_dat[k] : w_in_dat[k];
                end
                if (w_ld_skid[k]) begin
                    r_s_dat[k] <= w_in_dat[k];
                end
            end
        end
    end

    assign ready_up   = ~w_s_vld[0];
    assign valid_down = w_m_vld[STAGES-1];
    assign data_down  = r_m_dat[STAGES-1];

`ifdef HS_PIPE_CNT_EN
    localparam int OCC_W = $clog2(2*STAGES+1);

    logic             w_up_fire;
    logic             w_dn_fire;
    logic [15:0]      r_in_cnt;
    logic [15:0]      r_out_cnt;
    logic [OCC_W-1:0] r_occ;

    assign w_up_fire = valid_up & ready_up;
    assign w_dn_fire = valid_down & ready_down;

    // Transfer counters wrap naturally at 16 bits; occupancy tracks net flow.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= 16'd0;
            r_out_cnt <= 16'd0;
            r_occ     <= OCC_W'(0);
        end else begin
            if (w_up_fire) begin
                r_in_cnt <= r_in_cnt + 16'd1;
            end
            if (w_dn_fire) begin
                r_out_cnt <= r_out_cnt + 16'd1;
            end
            case ({w_up_fire, w_dn_fire})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign in_cnt  = r_in_cnt;
    assign out_cnt = r_out_cnt;
    assign occ     = r_occ;
`endif

endmodule

// File: tb/tb_hs_skid_pipe.sv
// Randomised bench for hs_skid_pipe: per-stage two-slot queue model plus an end-to-end FIFO scoreboard.
module tb_hs_skid_pipe;

    localparam int DATA_W = 8;
    localparam int STAGES = 3;
    localparam int CAP    = 2 * STAGES;
    localparam int OCC_W  = $clog2(CAP + 1);

    logic              sys_clk    = 1'b0;
    logic              rst_n      = 1'b0;
    logic              valid_up   = 1'b0;
    logic [DATA_W-1:0] data_up    = '0;
    logic              ready_down = 1'b0;
    wire               ready_up;
    wire               valid_down;
    wire  [DATA_W-1:0] data_down;
`ifdef HS_PIPE_CNT_EN
    wire  [15:0]       in_cnt;
    wire  [15:0]       out_cnt;
    wire  [OCC_W-1:0]  occ;
`endif

    hs_skid_pipe #(.DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .valid_up   (valid_up),
        .data_up    (data_up),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .ready_down (ready_down)
`ifdef HS_PIPE_CNT_EN
        ,
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt),
        .occ        (occ)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int                n_checks = 0;
    int                n_pass   = 0;
    // each stage is a queue of at most two beats; index 0 is the oldest
    logic [DATA_W-1:0] mq   [STAGES][2];
    int                mcnt [STAGES];
    logic [DATA_W-1:0] sb   [$];
    logic [15:0]       m_in  = 16'd0;
    logic [15:0]       m_out = 16'd0;
    bit                last_vd, last_ru, up_obs, dn_obs;
    logic [DATA_W-1:0] last_dd;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic model_clear();
        for (int k = 0; k < STAGES; k++) mcnt[k] = 0;
        sb.delete();
        m_in  = 16'd0;
        m_out = 16'd0;
    endtask

    // One clock edge of the reference: a stage with <2 beats is ready,
    // a stage with >=1 beat offers its oldest beat downstream.
    task automatic model_edge();
        bit                rdy  [STAGES];
        bit                ordy [STAGES];
        logic [DATA_W-1:0] d;
        for (int k = 0; k < STAGES; k++) rdy[k] = (mcnt[k] < 2);
        for (int k = 0; k < STAGES; k++) begin
            if (k == STAGES - 1) ordy[k] = ready_down;
            else                 ordy[k] = rdy[k+1];
        end
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (mcnt[k] > 0 && ordy[k]) begin
                d        = mq[k][0];
                mq[k][0] = mq[k][1];
                mcnt[k]--;
                if (k == STAGES - 1) begin
                    m_out++;
                end else begin
                    mq[k+1][mcnt[k+1]] = d;
                    mcnt[k+1]++;
                end
            end
        end
        if (valid_up && rdy[0]) begin
            mq[0][mcnt[0]] = data_up;
            mcnt[0]++;
            sb.push_back(data_up);
            m_in++;
        end
    endtask

    task automatic sample_and_compare();
        int occ_m;
        last_vd = valid_down;
        last_ru = ready_up;
        last_dd = data_down;
        check_val("ready_up", ready_up, mcnt[0] < 2);
        check_val("valid_down", valid_down, mcnt[STAGES-1] > 0);
        if (mcnt[STAGES-1] > 0) check_val("data_down", data_down, mq[STAGES-1][0]);
        occ_m = 0;
        for (int k = 0; k < STAGES; k++) occ_m += mcnt[k];
`ifdef HS_PIPE_CNT_EN
        check_val("in_cnt", in_cnt, m_in);
        check_val("out_cnt", out_cnt, m_out);
        check_val("occ", occ, occ_m);
`endif
    endtask

    task automatic step();
        @(posedge sys_clk);
        up_obs = last_ru && valid_up;
        dn_obs = last_vd && ready_down;
        if (dn_obs) begin
            check_val("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) check_val("sb_order", last_dd, sb.pop_front());
        end
        model_edge();
        #1;
        sample_and_compare();
    endtask

    task automatic latency_probe(input logic [DATA_W-1:0] d, input string tag);
        int lat;
        valid_up   = 1'b1;
        data_up    = d;
        ready_down = 1'b1;
        step();
        valid_up = 1'b0;
        lat = 1;
        while (!valid_down && lat < 64) begin
            step();
            lat++;
        end
        check_val(tag, lat, STAGES);
        check_val({tag, "_data"}, data_down, d);
        step();
    endtask

    task automatic drain();
        valid_up   = 1'b0;
        ready_down = 1'b1;
        repeat (4 * CAP) step();
        check_val("drained", sb.size(), 0);
    endtask

    // Full-rate burst: after priming, every cycle must deliver one beat.
    task automatic burst_throughput(input logic [DATA_W-1:0] base);
        int n_dn;
        n_dn       = 0;
        valid_up   = 1'b1;
        ready_down = 1'b1;
        data_up    = base;
        for (int i = 0; i < 40; i++) begin
            step();
            if (up_obs) data_up = data_up + 8'd1;
            if (i >= 20 && dn_obs) n_dn++;
        end
        check_val("throughput", n_dn, 20);
    endtask

    initial begin
        int acc;
        int sent;
        int guard;

        model_clear();
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("rst_valid_down", valid_down, 0);
        check_val("rst_ready_up", ready_up, 1);
        check_val("rst_data_down", data_down, 0);
        #2 rst_n = 1'b1;
        sample_and_compare();

        latency_probe(8'hA5, "latency");

        // back-to-back 1..5 at full rate
        ready_down = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            valid_up = 1'b1;
            data_up  = 8'(i);
            step();
        end
        drain();

        // capacity with the consumer stalled
        acc        = 0;
        ready_down = 1'b0;
        valid_up   = 1'b1;
        data_up    = 8'h40;
        for (int i = 0; i < 3 * CAP; i++) begin
            step();
            if (up_obs) begin
                acc++;
                data_up = data_up + 8'd1;
            end
        end
        check_val("capacity", acc, CAP);
        check_val("cap_head_valid", valid_down, 1);
        check_val("cap_head_data", data_down, 8'h40);

        // alternating ready_down while the producer keeps streaming
        for (int i = 0; i < 16; i++) begin
            ready_down = (i % 2 == 0);
            step();
            if (up_obs) data_up = data_up + 8'd1;
        end
        drain();

        burst_throughput(8'h80);

        // 1000 beats of an incrementing pattern under random back-pressure
        sent  = 0;
        guard = 0;
        while (sent < 1000 && guard < 20000) begin
            valid_up   = ($urandom_range(0, 3) != 0);
            data_up    = sent[7:0];
            ready_down = $urandom_range(0, 1);
            step();
            if (up_obs) sent++;
            guard++;
        end
        check_val("random_sent", sent, 1000);
        burst_throughput(8'hC0);
        drain();

        // asynchronous reset between edges with three beats held
        ready_down = 1'b0;
        valid_up   = 1'b1;
        data_up    = 8'h11;
        repeat (3) begin
            step();
            if (up_obs) data_up = data_up + 8'd1;
        end
        valid_up = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid_down", valid_down, 0);
        check_val("mid_rst_ready_up", ready_up, 1);
        check_val("mid_rst_data_down", data_down, 0);
        model_clear();
        #3 rst_n = 1'b1;
        sample_and_compare();
        latency_probe(8'h5C, "post_rst_latency");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
